// File: rtl/config_frame_block_pkg.sv
// Shared types for the serial configuration frame block: op encodings,
// FSM state encoding and the pulse counter width.
package config_frame_block_pkg;

   typedef enum logic {
      OP_WRITE    = 1'b0,
      OP_READBACK = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAYLOAD,
      PAR,
      COMMIT
   } state_e;

   // Holds PULSE_LEN in the range 1..15.
   localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/config_frame_block_if.sv
// Serial configuration chain link: frame start plus one data bit per cycle
// in each direction.
interface config_frame_block_if;
   logic cfg_in_start;
   logic cfg_bit_in;
   logic cfg_out_start;
   logic cfg_bit_out;

   // Upstream driver / downstream observer.
   modport master (
      output cfg_in_start, cfg_bit_in,
      input  cfg_out_start, cfg_bit_out
   );

   // The configuration block itself.
   modport slave (
      input  cfg_in_start, cfg_bit_in,
      output cfg_out_start, cfg_bit_out
   );
endinterface

// File: rtl/config_frame_block_cfg_pulse_gen.sv
// Fabric reset pulse: a commit loads PULSE_LEN, the output stays high
// while the down-counter is non-zero.
module cfg_pulse_gen
   import config_frame_block_pkg::*;
#(
   parameter int PULSE_LEN = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   output logic pulse_o
);

   logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i)
         cnt_d = PULSE_CNT_W'(PULSE_LEN);
      else if (cnt_q != '0)
         cnt_d = cnt_q - PULSE_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/config_frame_block.sv
// Daisy-chained configuration block: forwards the serial stream with one
// cycle of delay, captures matching write frames and answers readbacks.
module config_frame_block
   import config_frame_block_pkg::*;
#(
   parameter int CFG_SIZE  = 153,
   parameter int ID_WIDTH  = 3,
   parameter int ID        = 0,
   parameter int PULSE_LEN = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   config_frame_block_if.slave bus,
   output logic [CFG_SIZE-1:0] cfg,
   output logic                cfg_sr_pulse,
   output logic                cfg_valid,
   output logic                cfg_err
);

   localparam int CNT_W = $clog2(CFG_SIZE + 1);
   localparam logic [ID_WIDTH-1:0] MY_ID    = ID_WIDTH'(ID);
   localparam logic [ID_WIDTH-1:0] BCAST_ID = '1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   op_e                 op_q, op_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [CFG_SIZE-1:0] shadow_q, shadow_d;
   logic [CFG_SIZE-1:0] cfg_q, cfg_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                out_start_q;
   logic                out_bit_q, out_bit_d;
   logic                commit;
   logic                wr_match, rb_match;

   // Only meaningful once the header is complete (PAYLOAD and PAR).
   assign wr_match = (op_q == OP_WRITE) && ((id_q == MY_ID) || (id_q == BCAST_ID));
   assign rb_match = (op_q == OP_READBACK) && (id_q == MY_ID);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      id_d      = id_q;
      shadow_d  = shadow_q;
      cfg_d     = cfg_q;
      valid_d   = valid_q;
      err_d     = err_q;
      commit    = 1'b0;
      out_bit_d = bus.cfg_bit_in;

      if (bus.cfg_in_start) begin
         // A start always wins, even mid-frame: the old frame is dropped.
         state_d = HDR;
         cnt_d   = '0;
         op_d    = op_e'(bus.cfg_bit_in);
      end else begin
         unique case (state_q)
            IDLE: ;
            HDR: begin
               id_d = ID_WIDTH'({id_q, bus.cfg_bit_in});
               if (cnt_q == CNT_W'(ID_WIDTH - 1)) begin
                  state_d  = PAYLOAD;
                  cnt_d    = '0;
                  // Readback shifts cfg out of the shadow; a write shifts
                  // every preloaded bit out before it reaches PAR.
                  shadow_d = cfg_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PAYLOAD: begin
               if (rb_match) out_bit_d = shadow_q[0];
               if (wr_match || rb_match)
                  shadow_d = CFG_SIZE'({bus.cfg_bit_in, shadow_q} >> 1);
               if (cnt_q == CNT_W'(CFG_SIZE - 1)) begin
                  state_d = PAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PAR: begin
               state_d = COMMIT;
               if (rb_match) out_bit_d = ^cfg_q;
               // cfg loads on the PAR->COMMIT edge so it is live in COMMIT.
               if (wr_match) begin
                  if (bus.cfg_bit_in == ^shadow_q) begin
                     cfg_d   = shadow_q;
                     valid_d = 1'b1;
                     err_d   = 1'b0;
                     commit  = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= OP_WRITE;
         id_q        <= '0;
         shadow_q    <= '0;
         cfg_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         out_start_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         id_q        <= id_d;
         shadow_q    <= shadow_d;
         cfg_q       <= cfg_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         out_start_q <= bus.cfg_in_start;
         out_bit_q   <= out_bit_d;
      end
   end

   cfg_pulse_gen #(
      .PULSE_LEN (PULSE_LEN)
   ) u_pulse (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (commit),
      .pulse_o (cfg_sr_pulse)
   );

   assign bus.cfg_out_start = out_start_q;
   assign bus.cfg_bit_out   = out_bit_q;
   assign cfg               = cfg_q;
   assign cfg_valid         = valid_q;
   assign cfg_err           = err_q;

endmodule

// File: doc/config_frame_block.md
CONFIG_FRAME_BLOCK -- requirements
Module: config_frame_block

Interface
REQ-001 The block SHALL take parameter CFG_SIZE, default 153, the active configuration width in bits.
REQ-002 The block SHALL take parameter ID_WIDTH, default 3, the header ID field width.
REQ-003 The block SHALL take parameter ID, default 0, this block's address; the all-ones ID is reserved for broadcast.
REQ-004 The block SHALL take parameter PULSE_LEN, default 2, the cfg_sr_pulse length in cycles (1..15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port cfg_in_start, input, 1 bit: frame start, high in the cycle carrying frame bit 0.
REQ-008 The block SHALL have port cfg_bit_in, input, 1 bit: serial frame data, one bit per cycle.
REQ-009 The block SHALL have port cfg_out_start, output, 1 bit: frame start to the downstream block.
REQ-010 The block SHALL have port cfg_bit_out, output, 1 bit: serial data to the downstream block.
REQ-011 The block SHALL have port cfg, output, CFG_SIZE bits: active configuration.
REQ-012 The block SHALL have port cfg_sr_pulse, output, 1 bit: fabric reset pulse after a commit.
REQ-013 The block SHALL have port cfg_valid, output, 1 bit: at least one successful commit since reset.
REQ-014 The block SHALL have port cfg_err, output, 1 bit: sticky parity-error flag.

Function
REQ-015 Frame format, one bit per cycle: bit 0 = op (0 write, 1 readback); next ID_WIDTH bits = target ID, MSB first; next CFG_SIZE bits = payload, LSB first; last bit = even parity over the payload. Frame length = CFG_SIZE+ID_WIDTH+2 cycles.
REQ-016 The FSM SHALL have states IDLE, HDR, PAYLOAD, PAR and COMMIT. Transitions: cfg_in_start moves the FSM from any state to HDR with op captured; HDR exits after ID_WIDTH bits; PAYLOAD exits after CFG_SIZE bits; PAR lasts 1 cycle; COMMIT lasts 1 cycle and returns to IDLE.
REQ-017 A frame matches when the header ID equals ID or is all-ones; a readback with the broadcast ID SHALL NOT match.
REQ-018 Forwarding: cfg_out_start and cfg_bit_out SHALL equal cfg_in_start and cfg_bit_in delayed exactly 1 cycle, for every frame.
REQ-019 Exception to REQ-018: for a matched readback, the forwarded payload bits SHALL be the active cfg bits (LSB first) and the forwarded parity bit SHALL be the even parity of cfg.
REQ-020 A matched write SHALL shift payload into a CFG_SIZE shadow register; cfg SHALL NOT change during the frame.
REQ-021 In COMMIT, for a matched write whose received parity equals the shadow parity, the block SHALL load cfg from the shadow, set cfg_valid, clear cfg_err, and assert cfg_sr_pulse for exactly PULSE_LEN cycles starting in the cycle cfg updates.
REQ-022 For a matched write with a parity mismatch, the block SHALL set cfg_err and leave cfg, cfg_valid and cfg_sr_pulse unchanged.
REQ-023 cfg_in_start mid-frame SHALL abort the current frame (shadow discarded, no commit) and start a new header in the same cycle; forwarding is unaffected.
REQ-024 A new frame starting during an active cfg_sr_pulse SHALL NOT shorten or restart that pulse; a later commit restarts the pulse counter.
REQ-025 cfg_bit_in outside a frame (IDLE) SHALL be forwarded per REQ-018 and otherwise ignored.
REQ-026 Counters SHALL be sized to $clog2(CFG_SIZE+1) and SHALL NOT wrap within a frame.

Reset
REQ-027 While rst_n is low: FSM=IDLE; cfg, shadow = 0; cfg_valid, cfg_err, cfg_sr_pulse, cfg_out_start, cfg_bit_out = 0.
REQ-028 A reset mid-frame SHALL discard the frame; after rst_n rises, the block SHALL wait for the next cfg_in_start.

Structure
REQ-029 The op encodings (OP_WRITE, OP_READBACK) and the FSM state enum SHALL live in the shared config package.
REQ-030 The block SHALL contain one sub-module, cfg_pulse_gen, a PULSE_LEN down-counter driving cfg_sr_pulse.

Verification (bench: CFG_SIZE=8, ID_WIDTH=3, ID=5, PULSE_LEN=2)
REQ-031 Write frame op=0, id=101, payload 0xA5, parity 0 -> cfg=0xA5 in cycle 13 after start, cfg_valid=1, cfg_sr_pulse high for cycles 13-14.
REQ-032 Same frame with parity 1 -> cfg_err=1, cfg unchanged, no pulse; a following good write of 0x3C -> cfg=0x3C, cfg_err=0.
REQ-033 Readback op=1, id=101, with cfg=0x3C -> cfg_bit_out payload bits are 0,0,1,1,1,1,0,0 and parity 0, each delayed 1 cycle; cfg unchanged.
REQ-034 Write to id=011 -> cfg unchanged, output stream equals the input stream delayed 1 cycle; broadcast id=111 write of 0x0F -> cfg=0x0F.
REQ-035 cfg_in_start re-asserted at payload bit 4, followed by a full frame with 0x81 -> only 0x81 is committed, exactly one pulse.
REQ-036 rst_n low at payload bit 3 -> all outputs 0 immediately; the next complete frame commits normally.
